// File: rtl/pll_phase_stepper.sv
// Phase stepper for a dynamic-phase-shift PLL: moves one output's phase to an
// absolute position by issuing PSPULSE steps along the shorter direction, then
// waits for LOCK. Tracks the current position of every channel.
module pll_phase_stepper #(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned PULSE_LEN    = 2,
  parameter int unsigned GAP_LEN      = 6,
  parameter int unsigned LOCK_TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [1:0] i_req_ch,
  input  logic [5:0] i_req_phase,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  input  logic [1:0] i_rd_ch,
  output logic [5:0] o_rd_phase,
  output logic [2:0] o_pssel,
  output logic       o_psdir,
  output logic       o_pspulse,
  input  logic       i_lock
);

  localparam int unsigned TW = 16;

  typedef enum logic [2:0] {StIdle, StCalc, StPulse, StGap, StWaitLock, StDone} state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [TW-1:0]   r_tmr;
  logic [1:0]      r_ch;
  logic [5:0]      r_phase;
  logic [5:0]      r_steps;
  logic [5:0]      r_cur [4];
  logic [2:0]      r_pssel;
  logic            r_psdir;
  logic            r_pspulse;
  logic            r_busy;
  logic            r_ready;
  logic            r_done;
  logic            r_err;

  logic            w_accept;
  logic            w_ch_ok;
  logic [5:0]      w_diff;
  logic            w_retard;
  logic [5:0]      w_count;
  logic            w_step;
  logic            w_fin;
  logic            w_fin_err;

  assign w_accept = (r_state == StIdle) && i_req_valid;
  assign w_ch_ok  = 32'(r_ch) < NUM_CH;
  assign w_diff   = r_phase - r_cur[r_ch];
  assign w_retard = w_diff > 6'd32;
  assign w_count  = w_retard ? (6'd0 - w_diff) : w_diff;

  // Next-state decode and step/finish strobes.
  always_comb begin
    w_state_next = r_state;
    w_step       = 1'b0;
    w_fin        = 1'b0;
    w_fin_err    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_req_valid) w_state_next = StCalc;
      end
      StCalc: begin
        if (!w_ch_ok) begin
          w_state_next = StDone;
          w_fin        = 1'b1;
          w_fin_err    = 1'b1;
        end else if (w_diff == 6'd0) begin
          w_state_next = StDone;
          w_fin        = 1'b1;
        end else begin
          w_state_next = StPulse;
        end
      end
      StPulse: begin
        if (r_tmr == TW'(PULSE_LEN - 1)) w_state_next = StGap;
      end
      StGap: begin
        if (r_tmr == TW'(GAP_LEN - 1)) begin
          w_step       = 1'b1;
          w_state_next = (r_steps == 6'd1) ? StWaitLock : StPulse;
        end
      end
      StWaitLock: begin
        if (i_lock) begin
          w_state_next = StDone;
          w_fin        = 1'b1;
        end else if (r_tmr == TW'(LOCK_TIMEOUT - 1)) begin
          w_state_next = StDone;
          w_fin        = 1'b1;
          w_fin_err    = 1'b1;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State register, datapath and registered outputs (decoded from next state).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_tmr     <= '0;
      r_ch      <= '0;
      r_phase   <= '0;
      r_steps   <= '0;
      for (int i = 0; i < 4; i++) r_cur[i] <= '0;
      r_pssel   <= '0;
      r_psdir   <= 1'b0;
      r_pspulse <= 1'b0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Timer restarts on every state change, including GAP -> PULSE.
      r_tmr   <= (w_state_next != r_state) ? '0 : r_tmr + TW'(1);
      if (w_accept) begin
        r_ch    <= i_req_ch;
        r_phase <= i_req_phase;
        r_err   <= 1'b0;
      end
      if (r_state == StCalc) begin
        r_pssel <= {1'b0, r_ch};
        r_psdir <= w_retard;
        r_steps <= w_count;
      end
      if (w_step) begin
        r_cur[r_ch] <= r_psdir ? r_cur[r_ch] - 6'd1 : r_cur[r_ch] + 6'd1;
        r_steps     <= r_steps - 6'd1;
      end
      if (w_fin) r_err <= w_fin_err;
      r_pspulse <= (w_state_next == StPulse);
      r_busy    <= (w_state_next != StIdle);
      r_ready   <= (w_state_next == StIdle);
      r_done    <= (w_state_next == StDone);
    end
  end

  assign o_req_ready = r_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_pssel     = r_pssel;
  assign o_psdir     = r_psdir;
  assign o_pspulse   = r_pspulse;
  assign o_rd_phase  = (32'(i_rd_ch) < NUM_CH) ? r_cur[i_rd_ch] : 6'd0;

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Directed bench for pll_phase_stepper with hand-computed expectations.
module tb_pll_phase_stepper;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_ch;
  logic [5:0] req_phase;
  logic       busy, done, err;
  logic [1:0] rd_ch;
  logic [5:0] rd_phase;
  logic [2:0] pssel;
  logic       psdir, pspulse;
  logic       lock;

  int n_total = 0;
  int n_bad   = 0;

  pll_phase_stepper dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_ch    (req_ch),
    .i_req_phase (req_phase),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .i_rd_ch     (rd_ch),
    .o_rd_phase  (rd_phase),
    .o_pssel     (pssel),
    .o_psdir     (psdir),
    .o_pspulse   (pspulse),
    .i_lock      (lock)
  );

  always #5 clk = ~clk;

  // Readback of one channel, sampled mid-cycle.
  task automatic read_ch(input logic [1:0] ch, output logic [5:0] val);
    rd_ch = ch;
    #1 val = rd_phase;
  endtask

  // Issue one request and watch it to completion. lat counts edges from the
  // accepting edge T to the edge at which done is first seen (-1 on timeout).
  // With glitch set, req_valid is held high while busy and lock drops during pulses.
  task automatic run_req(input logic [1:0] ch, input logic [5:0] ph, input bit glitch,
                         output int lat, output int np, output int hi, output int maxrun,
                         output logic dir, output logic [2:0] sel, output logic errv,
                         output bit saw63);
    int run;
    logic prev;
    @(negedge clk);
    req_valid = 1'b1; req_ch = ch; req_phase = ph; rd_ch = ch;
    @(posedge clk);
    #1 req_valid = 1'b0; req_ch = 2'd0; req_phase = 6'd0;
    lat = -1; np = 0; hi = 0; run = 0; maxrun = 0; prev = 1'b0;
    dir = 1'bx; sel = 3'bx; errv = 1'bx; saw63 = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (pspulse) begin
        hi++; run++;
        if (run > maxrun) maxrun = run;
        if (!prev) begin np++; dir = psdir; sel = pssel; end
      end else begin
        run = 0;
      end
      prev = pspulse;
      if (rd_phase == 6'd63) saw63 = 1'b1;
      if (glitch) begin
        req_valid = !done; req_ch = 2'd2; req_phase = 6'd40;
        lock = !pspulse;
      end
      if (done) begin
        lat = k + 1; errv = err;
        break;
      end
    end
    req_valid = 1'b0;
    if (glitch) lock = 1'b1;
  endtask

  task automatic test_reset;
    logic [5:0] v;
    rst = 1'b1; req_valid = 1'b0; req_ch = 2'd0; req_phase = 6'd0; rd_ch = 2'd0; lock = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    n_total++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_total++; if ({done, err, pspulse, psdir} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags got=%b want=0000", {done, err, pspulse, psdir}); end
    n_total++; if (pssel !== 3'd0) begin n_bad++; $display("FAIL reset_pssel got=%0d want=0", pssel); end
    for (int c = 0; c < 3; c++) begin
      read_ch(2'(c), v);
      n_total++; if (v !== 6'd0) begin n_bad++; $display("FAIL reset_cur%0d got=%0d want=0", c, v); end
    end
  endtask

  task automatic test_advance;
    int lat, np, hi, mr; logic d, e; logic [2:0] s; bit w; logic [5:0] v;
    run_req(2'd1, 6'd3, 1'b0, lat, np, hi, mr, d, s, e, w);
    n_total++; if (lat != 27) begin n_bad++; $display("FAIL adv_latency got=%0d want=27", lat); end
    n_total++; if (np != 3) begin n_bad++; $display("FAIL adv_pulses got=%0d want=3", np); end
    n_total++; if (hi != 6 || mr != 2) begin
      n_bad++; $display("FAIL adv_width got hi=%0d max=%0d want hi=6 max=2", hi, mr); end
    n_total++; if (d !== 1'b0 || s !== 3'd1) begin
      n_bad++; $display("FAIL adv_dir_sel got dir=%b sel=%0d want dir=0 sel=1", d, s); end
    n_total++; if (e !== 1'b0) begin n_bad++; $display("FAIL adv_err got=%b want=0", e); end
    read_ch(2'd1, v);
    n_total++; if (v !== 6'd3) begin n_bad++; $display("FAIL adv_rd got=%0d want=3", v); end
  endtask

  task automatic test_retard_wrap;
    int lat, np, hi, mr; logic d, e; logic [2:0] s; bit w; logic [5:0] v;
    run_req(2'd0, 6'd2, 1'b0, lat, np, hi, mr, d, s, e, w);
    n_total++; if (lat != 19 || np != 2) begin
      n_bad++; $display("FAIL pre_wrap got lat=%0d np=%0d want lat=19 np=2", lat, np); end
    run_req(2'd0, 6'd62, 1'b0, lat, np, hi, mr, d, s, e, w);
    n_total++; if (lat != 35 || np != 4) begin
      n_bad++; $display("FAIL wrap_lat_np got lat=%0d np=%0d want lat=35 np=4", lat, np); end
    n_total++; if (d !== 1'b1 || s !== 3'd0) begin
      n_bad++; $display("FAIL wrap_dir_sel got dir=%b sel=%0d want dir=1 sel=0", d, s); end
    n_total++; if (w !== 1'b1) begin n_bad++; $display("FAIL wrap_seen63 got=%b want=1", w); end
    read_ch(2'd0, v);
    n_total++; if (v !== 6'd62) begin n_bad++; $display("FAIL wrap_rd got=%0d want=62", v); end
  endtask

  task automatic test_same_phase;
    int lat, np, hi, mr; logic d, e; logic [2:0] s; bit w;
    run_req(2'd0, 6'd62, 1'b0, lat, np, hi, mr, d, s, e, w);
    n_total++; if (lat != 2 || np != 0) begin
      n_bad++; $display("FAIL same_lat_np got lat=%0d np=%0d want lat=2 np=0", lat, np); end
    n_total++; if (e !== 1'b0) begin n_bad++; $display("FAIL same_err got=%b want=0", e); end
  endtask

  task automatic test_bad_channel;
    int lat, np, hi, mr; logic d, e; logic [2:0] s; bit w; logic [5:0] v0, v1, v2, v3;
    run_req(2'd3, 6'd10, 1'b0, lat, np, hi, mr, d, s, e, w);
    n_total++; if (lat != 2 || np != 0) begin
      n_bad++; $display("FAIL badch_lat_np got lat=%0d np=%0d want lat=2 np=0", lat, np); end
    n_total++; if (e !== 1'b1) begin n_bad++; $display("FAIL badch_err got=%b want=1", e); end
    read_ch(2'd0, v0); read_ch(2'd1, v1); read_ch(2'd2, v2); read_ch(2'd3, v3);
    n_total++; if ({v0, v1, v2, v3} !== {6'd62, 6'd3, 6'd0, 6'd0}) begin
      n_bad++; $display("FAIL badch_cur got=%0d,%0d,%0d,%0d want=62,3,0,0", v0, v1, v2, v3); end
    repeat (3) @(negedge clk);
    n_total++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_hold got=%b want=1", err); end
    // err clears on the accepting edge of the next request.
    req_valid = 1'b1; req_ch = 2'd1; req_phase = 6'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n_total++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear got=%b want=0", err); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_lock_timeout;
    int lat, np, hi, mr; logic d, e; logic [2:0] s; bit w; logic [5:0] v;
    lock = 1'b0;
    run_req(2'd2, 6'd1, 1'b0, lat, np, hi, mr, d, s, e, w);
    lock = 1'b1;
    n_total++; if (lat != 265 || np != 1) begin
      n_bad++; $display("FAIL timeout_lat_np got lat=%0d np=%0d want lat=265 np=1", lat, np); end
    n_total++; if (e !== 1'b1) begin n_bad++; $display("FAIL timeout_err got=%b want=1", e); end
    read_ch(2'd2, v);
    n_total++; if (v !== 6'd1) begin n_bad++; $display("FAIL timeout_rd got=%0d want=1", v); end
  endtask

  task automatic test_back_to_back;
    int lat, np, hi, mr; logic d, e; logic [2:0] s; bit w; logic [5:0] v;
    // 62 -> 3 is five advance steps; stray requests and lock drops must not matter.
    run_req(2'd0, 6'd3, 1'b1, lat, np, hi, mr, d, s, e, w);
    n_total++; if (lat != 43 || np != 5) begin
      n_bad++; $display("FAIL b2b_lat_np got lat=%0d np=%0d want lat=43 np=5", lat, np); end
    n_total++; if (d !== 1'b0 || e !== 1'b0) begin
      n_bad++; $display("FAIL b2b_dir_err got dir=%b err=%b want 0 0", d, e); end
    run_req(2'd0, 6'd3, 1'b0, lat, np, hi, mr, d, s, e, w);
    n_total++; if (lat != 2) begin n_bad++; $display("FAIL b2b_second got=%0d want=2", lat); end
    read_ch(2'd2, v);
    n_total++; if (v !== 6'd1) begin n_bad++; $display("FAIL b2b_ignored got=%0d want=1", v); end
  endtask

  task automatic test_reset_mid;
    int rises; logic prev; logic [5:0] v0, v1;
    @(negedge clk);
    req_valid = 1'b1; req_ch = 2'd1; req_phase = 6'd8;
    @(posedge clk);
    // Keep a different request pending through the whole run.
    #1 req_ch = 2'd0; req_phase = 6'd20;
    rises = 0; prev = 1'b0;
    for (int k = 0; k < 100 && rises < 2; k++) begin
      @(negedge clk);
      if (pspulse && !prev) rises++;
      prev = pspulse;
    end
    n_total++; if (rises != 2) begin n_bad++; $display("FAIL mid_second_pulse got=%0d want=2", rises); end
    n_total++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready_busy got=%b want=0", req_ready); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    n_total++; if ({pspulse, req_ready, busy} !== 3'b010) begin
      n_bad++; $display("FAIL mid_abort got pulse/ready/busy=%b want=010", {pspulse, req_ready, busy}); end
    read_ch(2'd1, v1); read_ch(2'd0, v0);
    n_total++; if (v1 !== 6'd0 || v0 !== 6'd0) begin
      n_bad++; $display("FAIL mid_cur got ch1=%0d ch0=%0d want 0 0", v1, v0); end
    repeat (12) @(negedge clk);
    n_total++; if (pspulse !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL mid_quiet got pulse=%b busy=%b want 0 0", pspulse, busy); end
  endtask

  initial begin
    test_reset;
    test_advance;
    test_retard_wrap;
    test_same_phase;
    test_bad_channel;
    test_lock_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_phase_stepper.md
PLL_PHASE_STEPPER -- requirements
Module: pll_phase_stepper

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, giving the number of PLL outputs under phase control (channels 0..NUM_CH-1).
REQ-002 SHALL have parameter PULSE_LEN, default 2, giving the PSPULSE high time in clk cycles (at least 1).
REQ-003 SHALL have parameter GAP_LEN, default 6, giving the PSPULSE low time after each pulse in clk cycles (at least 1).
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 255, giving the maximum WAIT_LOCK cycles before an error is reported.
REQ-005 clk  in  1  single clock; all logic is rising-edge on clk.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  phase-set request.
REQ-008 req_ready  out  1  high only in IDLE.
REQ-009 req_ch  in  2  target channel.
REQ-010 req_phase  in  6  target absolute phase position, 0..63.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 err  out  1  valid with done; set on bad channel or lock timeout.
REQ-014 rd_ch / rd_phase  in 2 / out 6  combinational readback of the tracked position of rd_ch (0 if out of range).
REQ-015 pssel  out  3  to PLL PSSEL; the channel being stepped.
REQ-016 psdir  out  1  to PLL PSDIR; 0 = advance (+1), 1 = retard (-1).
REQ-017 pspulse  out  1  to PLL PSPULSE.
REQ-018 lock  in  1  PLL LOCK, treated as synchronous to clk.

Function
REQ-019 SHALL implement states IDLE, CALC, PULSE, GAP, WAIT_LOCK, DONE, with all outputs except rd_phase registered.
REQ-020 SHALL accept a request on the edge where req_valid and req_ready are both high, latching req_ch and req_phase, then enter CALC.
REQ-021 In CALC, SHALL compute diff = (req_phase - cur[ch]) mod 64.
  - If diff is 0, SHALL go to DONE with err = 0.
  - If diff is 32 or less, SHALL set psdir = 0 and count = diff.
  - Otherwise SHALL set psdir = 1 and count = 64 - diff.
REQ-022 If req_ch is NUM_CH or greater, SHALL go from CALC straight to DONE with err = 1, issuing no pulse.
REQ-023 SHALL load pssel and psdir in CALC and hold them stable until IDLE.
REQ-024 In PULSE, pspulse SHALL be 1 for exactly PULSE_LEN cycles; then the block SHALL enter GAP.
REQ-025 In GAP, pspulse SHALL be 0 for exactly GAP_LEN cycles.
REQ-026 At the end of each GAP, SHALL update cur[ch] by +1 or -1 modulo 64 (63+1 = 0, 0-1 = 63) and decrement count.
REQ-027 At the end of GAP, SHALL return to PULSE if count is nonzero, else enter WAIT_LOCK.
REQ-028 WAIT_LOCK SHALL exit to DONE (err = 0) on the first cycle lock = 1.
REQ-029 If lock stays 0 for LOCK_TIMEOUT cycles, WAIT_LOCK SHALL exit to DONE with err = 1; cur[ch] keeps the stepped value.
REQ-030 DONE SHALL last one cycle with done = 1; err SHALL be held until the next accepted request; then the block SHALL return to IDLE.
REQ-031 Latency SHALL be: acceptance at edge T gives done at T+2 for count 0, and at T+3+count*(PULSE_LEN+GAP_LEN) when lock is already high.
REQ-032 req_valid outside IDLE SHALL be ignored, with no queuing.
REQ-033 Loss of lock outside WAIT_LOCK SHALL be ignored.

Reset
REQ-034 With rst high at a clk edge, the block SHALL enter IDLE with every cur[] = 0 and pssel = 0, psdir = 0, pspulse = 0, done = 0, err = 0, busy = 0, req_ready = 1.
REQ-035 Reset mid-operation SHALL abort immediately: pspulse drops at that edge, remaining steps are discarded, and tracking restarts at 0.
REQ-036 rst SHALL have priority over a simultaneous request.

Verification
REQ-037 Reset, then request ch 1, phase 3, lock = 1 -> 3 pulses, each 2 cycles high and 6 low, psdir = 0, pssel = 1; done at T+27, err = 0, rd_phase(1) = 3.
REQ-038 cur[0] = 2, request phase 62 -> 4 pulses with psdir = 1, passing through the 0->63 wrap; final rd_phase(0) = 62.
REQ-039 Request equal to the current phase -> no pspulse; done at T+2, err = 0.
REQ-040 req_ch = 3 -> no pulse; done with err = 1; all cur[] unchanged.
REQ-041 lock held 0 after 1 step -> done with err = 1 exactly 255 WAIT_LOCK cycles later; rd_phase reflects the step.
REQ-042 rst asserted during the second PULSE of a 5-step request -> pspulse = 0 and req_ready = 1 the next cycle, rd_phase = 0; req_valid during busy is never accepted.
